// File: rtl/frame_bit_counter.sv
// frame_bit_counter
//
// Frame sequencer for the serial receive/transmit paths. It divides an
// oversample tick into bit periods, tracks how many bits of the current frame
// have completed, and emits a strobe at the configured mid-bit sample point.
// Frame completion is reported as a level (done) and a one-cycle pulse
// (done_pulse).
//
// Build option: FBC_AUTO_RESTART_EN
//   undefined : DONE holds until clear is asserted or enable drops; a new frame
//               starts from IDLE once enable is sampled high.
//   defined   : DONE lasts a single cycle and, while enable stays high, the
//               next frame starts immediately with counters at 0.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   enable        in   frame in progress; low forces IDLE
//   clear         in   synchronous restart to IDLE; overrides enable
//   tick          in   one-cycle oversample tick; counted only in RUN
//   sample_idx    out  position within the current bit (0..SAMPLES_PER_BIT-1)
//   bit_idx       out  completed bits in the frame (0..BITS_PER_FRAME)
//   sample_strobe out  one-cycle pulse in the first cycle sample_idx == MID_SAMPLE
//   busy          out  state is RUN
//   done          out  state is DONE
//   done_pulse    out  one-cycle pulse on entry to DONE
//
// All outputs come straight from flops. busy and done together expose the
// FSM state (IDLE = neither).

module frame_bit_counter #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int BITS_PER_FRAME  = 10,
  parameter int MID_SAMPLE      = 8,
  localparam int SW = $clog2(SAMPLES_PER_BIT),
  localparam int BW = $clog2(BITS_PER_FRAME + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clear,
  input  logic          tick,
  output logic [SW-1:0] sample_idx,
  output logic [BW-1:0] bit_idx,
  output logic          sample_strobe,
  output logic          busy,
  output logic          done,
  output logic          done_pulse
);

  // Reject parameter sets the counters cannot represent.
  if (SAMPLES_PER_BIT < 2 || BITS_PER_FRAME < 1 ||
      MID_SAMPLE < 0 || MID_SAMPLE >= SAMPLES_PER_BIT) begin : g_param_check
    $error("frame_bit_counter: illegal parameters S=%0d B=%0d MID=%0d",
           SAMPLES_PER_BIT, BITS_PER_FRAME, MID_SAMPLE);
  end

  localparam logic [SW-1:0] S_LAST = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [SW-1:0] MID_V  = SW'(MID_SAMPLE);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sample_q, sample_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          strobe_q, strobe_d;
  logic          dpulse_q, dpulse_d;
  logic          busy_q, done_q;

  logic          abort;
  logic          run_tick;
  logic          at_last_sample;
  logic          at_last_bit;
  logic          frame_end;
  logic [SW-1:0] sample_inc;

  // clear and enable-low share the same effect; clear only differs in
  // priority, which does not matter once both lead to IDLE.
  assign abort          = clear || !enable;
  assign run_tick       = (state_q == ST_RUN) && tick;
  assign at_last_sample = (sample_q == S_LAST);
  assign at_last_bit    = (bit_q == B_LAST);
  assign frame_end      = run_tick && at_last_sample && at_last_bit;
  assign sample_inc     = sample_q + 1'b1;

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      strobe_q <= 1'b0;
      dpulse_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      strobe_q <= strobe_d;
      dpulse_q <= dpulse_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  if (frame_end) state_d = ST_DONE;
`ifdef FBC_AUTO_RESTART_EN
        ST_DONE: state_d = ST_RUN;
`else
        ST_DONE: state_d = ST_DONE;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the counters and pulse outputs.
  always_comb begin
    sample_d = sample_q;
    bit_d    = bit_q;
    strobe_d = 1'b0;
    dpulse_d = 1'b0;
    if (abort) begin
      sample_d = '0;
      bit_d    = '0;
    end else if (state_q == ST_DONE) begin
`ifdef FBC_AUTO_RESTART_EN
      // Back-to-back frame: leave DONE with fresh counters.
      sample_d = '0;
      bit_d    = '0;
`endif
    end else if (run_tick) begin
      if (!at_last_sample) begin
        sample_d = sample_inc;
        strobe_d = (sample_inc == MID_V);
      end else begin
        sample_d = '0;
        bit_d    = bit_q + 1'b1;
        // A wrap lands on sample 0; that only strobes when the sample point
        // is 0 and another bit of this frame follows.
        strobe_d = (MID_V == '0) && !at_last_bit;
        dpulse_d = at_last_bit;
      end
    end
  end

  assign sample_idx    = sample_q;
  assign bit_idx       = bit_q;
  assign sample_strobe = strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_pulse    = dpulse_q;

endmodule

// File: doc/frame_bit_counter.md
# frame_bit_counter

Parametrised frame sequencer for the serial network receiver and transmitter paths. It divides an oversampling tick into bit periods, tracks the bit index within a frame, and emits a mid-bit sample strobe. It also flags frame completion. Frame length, oversampling ratio and sample point are generics; one instance serves any frame format on the link.

## Interface
- SAMPLES_PER_BIT, 16, oversample ticks per bit; legal values are 2 or more.
- BITS_PER_FRAME, 10, bits per frame, including start and stop; legal values are 1 or more.
- MID_SAMPLE, 8, sample_idx value at which sample_strobe fires; must be less than SAMPLES_PER_BIT.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- enable  in  1  frame in progress; low forces IDLE.
- clear  in  1  synchronous restart to IDLE; overrides enable.
- tick  in  1  oversample tick, one cycle wide; counted only in RUN.
- sample_idx  out  SW=$clog2(SAMPLES_PER_BIT)  position within the current bit.
- bit_idx  out  BW=$clog2(BITS_PER_FRAME+1)  number of completed bits.
- sample_strobe  out  1  one-cycle pulse at the mid-bit point.
- busy  out  1  high while state is RUN.
- done  out  1  high while state is DONE.
- done_pulse  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Priority, highest first: rst_n low, clear, enable low, normal operation.
- When rst_n is low, clear is high, or enable is low:
  - state goes to IDLE.
  - sample_idx and bit_idx go to 0.
  - All pulse and level outputs go to 0.
- IDLE to RUN: enable is high and clear is low. A tick in the transition cycle is ignored.
- RUN, on each tick:
  - If sample_idx is below SAMPLES_PER_BIT-1, sample_idx increments.
  - Otherwise sample_idx wraps to 0 and bit_idx increments.
- RUN, without a tick: all counters hold.
- sample_strobe is high in exactly one cycle: the cycle after the tick that moves sample_idx to MID_SAMPLE. It therefore coincides with the first cycle in which sample_idx equals MID_SAMPLE.
- RUN to DONE: the tick that wraps sample_idx from SAMPLES_PER_BIT-1 while bit_idx equals BITS_PER_FRAME-1.
  - After that tick, bit_idx equals BITS_PER_FRAME, sample_idx is 0, done is 1 and done_pulse is 1 for one cycle.
- DONE:
  - Counters saturate; ticks are ignored.
  - bit_idx holds BITS_PER_FRAME.
  - Leaving DONE is covered under Configuration.
- Width rules: counters are unsigned and compared at their full declared width. bit_idx never exceeds BITS_PER_FRAME. sample_idx never exceeds SAMPLES_PER_BIT-1.
- Illegal parameters are rejected by an elaboration-time check.

## Timing
- Reset values: all outputs are 0 and state is IDLE.
- Tick to counter update: 1 cycle.
- Tick to sample_strobe: 1 cycle.
- enable rising to RUN: 1 cycle. The first countable tick is the cycle after enable is sampled high.
- Final tick to done and done_pulse: 1 cycle.
- With tick high every cycle and default parameters:
  - 160 counted ticks from the RUN entry to done.
  - The first sample_strobe occurs 8 counted ticks after RUN entry.
- clear or enable low mid-frame: counters are 0 on the next cycle. No done_pulse is emitted and no strobe is emitted in that cycle.
- Tick coincident with clear: the tick is dropped.

## Configuration
- Macro FBC_AUTO_RESTART_EN.
- Defined:
  - DONE lasts exactly one cycle.
  - If enable is still high and clear is low, the next state is RUN with counters at 0, so back-to-back frames need no enable toggle.
  - done is high for that single cycle only.
- Not defined:
  - DONE holds indefinitely until clear is asserted or enable is deasserted; then the block goes to IDLE.
  - A new frame requires enable to be sampled high from IDLE.

## Test plan
- Reset:
  - Stimulus: drive rst_n low for 2 cycles with enable=1 and tick=1.
  - Response: all outputs are 0; after release, busy=1 on the second cycle.
- Full default frame:
  - Stimulus: enable=1, tick every cycle.
  - Response: sample_strobe exactly 10 times, 16 cycles apart. bit_idx reaches 10. done_pulse is one cycle, exactly 160 ticks after RUN entry.
- Sparse ticks:
  - Stimulus: tick every 3rd cycle.
  - Response: counters change only on the cycle after a tick. Frame completes after 160 ticks, i.e. 480 cycles.
- Mid-frame abort:
  - Stimulus: clear at bit_idx=4, sample_idx=7, with tick=1.
  - Response: next cycle sample_idx=0, bit_idx=0, busy=0, no sample_strobe, no done_pulse.
- Saturation:
  - Build without the macro. Stimulus: keep enable=1 with ticks after done.
  - Response: bit_idx stays 10, sample_idx stays 0, done stays 1, no further pulses.
  - Then drop enable. Response: IDLE.
- Auto-restart:
  - Build with FBC_AUTO_RESTART_EN defined. Stimulus: 3 frames back-to-back.
  - Response: three done_pulses spaced 161 cycles apart. done is high for 1 cycle each time.
- Parameter sweep:
  - Stimulus: SAMPLES_PER_BIT=4, BITS_PER_FRAME=1, MID_SAMPLE=2.
  - Response: one strobe, then done after 4 ticks, with bit_idx=1.
